// File: rtl/serial_pkg.sv
// Shared definitions for the serial link transmitter and receiver.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    localparam int unsigned DATA_WIDTH = 4;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load, shift-right register presenting its LSB as the serial bit.
module piso_shift_reg
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             ser
);

    logic [WIDTH-1:0] shreg;

    // Load has priority over shift; zeros fill from the top.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= d;
        end else if (shift) begin
            shreg <= {1'b0, shreg[WIDTH-1:1]};
        end
    end

    assign ser = shreg[0];

endmodule

// File: rtl/serial_tx.sv
// Framed serial transmitter: start bit, WIDTH data bits LSB-first, STOP_BITS stop bits.
module serial_tx
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH     = DATA_WIDTH,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned     CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WIDTH - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_t        state;
    logic [CNT_W-1:0] bit_cnt;
    logic             stop_cnt;
    logic             accept;
    logic             shift_en;
    logic             ser_bit;

    assign load_ready = (state == IDLE) && !reset;
    assign accept     = load_valid && load_ready;
    // START shift pre-positions bit 1 so sout can be registered one edge ahead.
    assign shift_en   = (state == START) || (state == DATA);

    piso_shift_reg #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .shift (shift_en),
        .d     (d),
        .ser   (ser_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sout     <= LINE_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= START;
                        sout    <= LINE_START;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                START: begin
                    state <= DATA;
                    sout  <= ser_bit;
                end
                DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        state    <= STOP;
                        sout     <= LINE_IDLE;
                        stop_cnt <= 1'b0;
                    end else begin
                        sout    <= ser_bit;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (stop_cnt == LAST_STOP) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        stop_cnt <= stop_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    sout  <= LINE_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: one- and two-stop-bit instances against a frame-queue model.
module tb_serial_tx;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] d;
    logic         load_valid;
    logic         ready1, sout1, busy1, done1;
    logic         ready2, sout2, busy2, done2;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    // Model: remaining frame cycles and the frame's sout values, bit k = cycle k.
    int          rem  [2];
    logic [15:0] fb   [2];
    logic        dn_m [2];
    int          stops[2];

    always #5 clk = ~clk;

    serial_tx #(.WIDTH(W), .STOP_BITS(1)) dut1 (
        .clk(clk), .reset(reset), .d(d), .load_valid(load_valid),
        .load_ready(ready1), .sout(sout1), .busy(busy1), .done(done1)
    );

    serial_tx #(.WIDTH(W), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .d(d), .load_valid(load_valid),
        .load_ready(ready2), .sout(sout2), .busy(busy2), .done(done2)
    );

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                rem[i]  = 0;
                dn_m[i] = 1'b0;
            end else if (rem[i] > 0) begin
                fb[i]   = fb[i] >> 1;
                rem[i]  = rem[i] - 1;
                dn_m[i] = (rem[i] == 0);
            end else begin
                dn_m[i] = 1'b0;
                if (load_valid) begin
                    fb[i]  = (16'(d) << 1) | (((16'(1) << stops[i]) - 16'(1)) << (W + 1));
                    rem[i] = 1 + int'(W) + stops[i];
                end
            end
        end
    endtask

    task automatic step();
        logic gs, gb, gd, gr, es, eb, ed, er;
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            gs = (i == 0) ? sout1  : sout2;
            gb = (i == 0) ? busy1  : busy2;
            gd = (i == 0) ? done1  : done2;
            gr = (i == 0) ? ready1 : ready2;
            es = (rem[i] > 0) ? fb[i][0] : 1'b1;
            eb = (rem[i] > 0);
            ed = dn_m[i];
            er = (rem[i] == 0) && !reset;
            compared += 4;
            if (gs !== es) begin
                mismatched++;
                $display("FAIL sout[stop%0d] cyc=%0d got=%b exp=%b", stops[i], cyc, gs, es);
            end
            if (gb !== eb) begin
                mismatched++;
                $display("FAIL busy[stop%0d] cyc=%0d got=%b exp=%b", stops[i], cyc, gb, eb);
            end
            if (gd !== ed) begin
                mismatched++;
                $display("FAIL done[stop%0d] cyc=%0d got=%b exp=%b", stops[i], cyc, gd, ed);
            end
            if (gr !== er) begin
                mismatched++;
                $display("FAIL load_ready[stop%0d] cyc=%0d got=%b exp=%b", stops[i], cyc, gr, er);
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        load_valid = 1'b0;
        while ((rem[0] > 0 || rem[1] > 0) && n < 30) begin
            step();
            n++;
        end
        compared++;
        if (rem[0] > 0 || rem[1] > 0) begin
            mismatched++;
            $display("FAIL wait_idle cyc=%0d got=busy exp=idle within 30 cycles", cyc);
        end
        step();
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        load_valid = 1'b0;
        d          = '0;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [5:0] seq;
        wait_idle();
        d          = 4'b1100;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        seq = 6'b0;
        for (int k = 0; k < 6; k++) begin
            seq[k] = sout1;
            step();
        end
        compared++;
        if (seq !== 6'b111000) begin
            mismatched++;
            $display("FAIL basic_frame got=%b exp=%b (LSB = first cycle)", seq, 6'b111000);
        end
        compared++;
        if (done1 !== 1'b1 || sout1 !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_done got=done%b/sout%b exp=done1/sout1", done1, sout1);
        end
    endtask

    task automatic test_ignore_midframe();
        int  n = 0;
        int  prev;
        wait_idle();
        d          = 4'b1111;
        load_valid = 1'b1;
        step();
        d = 4'b0000;
        prev = rem[0];
        while (!(prev == 0 && rem[0] > 0) && n < 20) begin
            prev = rem[0];
            step();
            n++;
        end
        compared++;
        if (n >= 20) begin
            mismatched++;
            $display("FAIL ignore_second_accept got=no accept exp=accept on done cycle");
        end
        load_valid = 1'b0;
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int idle_cnt = 0;
        int prev;
        wait_idle();
        d          = 4'b1010;
        load_valid = 1'b1;
        step();
        d = 4'b0101;
        prev = rem[0];
        while (!(prev == 0 && rem[0] > 0) && n < 20) begin
            prev = rem[0];
            step();
            if (busy1 === 1'b0) idle_cnt++;
            n++;
        end
        load_valid = 1'b0;
        compared++;
        if (idle_cnt !== 1) begin
            mismatched++;
            $display("FAIL b2b_gap got=%0d exp=1 idle cycles", idle_cnt);
        end
        wait_idle();
    endtask

    task automatic test_reset_midframe();
        wait_idle();
        d          = 4'b0110;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        compared++;
        if (sout1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) begin
            mismatched++;
            $display("FAIL abort got=sout%b busy%b done%b exp=sout1 busy0 done0", sout1, busy1, done1);
        end
        reset = 1'b0;
        step();
        step();
    endtask

    task automatic test_stop2();
        logic [6:0] seq;
        wait_idle();
        d          = 4'b0001;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        seq = 7'b0;
        for (int k = 0; k < 7; k++) begin
            seq[k] = sout2;
            step();
        end
        compared++;
        if (seq !== 7'b1100010 || done2 !== 1'b1) begin
            mismatched++;
            $display("FAIL stop2_frame got=%b done=%b exp=%b done=1", seq, done2, 7'b1100010);
        end
    endtask

    task automatic test_idle_hold();
        wait_idle();
        load_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            d = W'($urandom);
            step();
        end
    endtask

    task automatic test_random();
        wait_idle();
        for (int k = 0; k < 400; k++) begin
            reset      = ($urandom_range(0, 49) == 0);
            load_valid = 1'($urandom);
            d          = W'($urandom);
            step();
        end
        reset      = 1'b0;
        load_valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        stops[0] = 1;
        stops[1] = 2;
        rem[0] = 0;  rem[1] = 0;
        fb[0] = '0;  fb[1] = '0;
        dn_m[0] = 1'b0; dn_m[1] = 1'b0;
        reset = 1'b1;
        load_valid = 1'b0;
        d = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_ignore_midframe();
        test_back_to_back();
        test_reset_midframe();
        test_stop2();
        test_idle_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
